control_unit_fsm: RTL
=====================

// Module: control_unit_fsm
// PURPOSE
//  Parametrised, clocked successor to the combinational opcode decoder of the 8-bit CPU.
//  Registers the decoded control word, owns the data-memory READ/WRITE handshake with BUSYWAIT,
//  stalls the PC while memory is busy, and flags illegal opcodes and memory timeouts.
//  Sits between the instruction memory and the datapath (ALU, reg file, PC, data memory).
// PARAMETERS
//  OPCODE_W     8    opcode width (instruction bits [31:24] at OPCODE_W=8)
//  ALUOP_W      3    ALU operation code width
//  TIMEOUT_CYC  255  max BUSYWAIT-high cycles before abort; 0 disables the timeout
//  TMO_W        8    timeout counter width; TIMEOUT_CYC must fit in TMO_W bits
// PORTS
//  CLK           in   1         clock, all state updates on posedge
//  RESET_N       in   1         asynchronous, active-low reset
//  OPCODE        in   OPCODE_W  opcode of the current instruction
//  INSTR_VALID   in   1         OPCODE valid this cycle
//  BUSYWAIT      in   1         data memory busy
//  ALUOP         out  ALUOP_W   ALU select
//  MUX_2SCMPL    out  1         select negated operand 2
//  MUX_IMMD      out  1         select immediate operand
//  REG_WRITE_EN  out  1         register file write enable (final, gated)
//  BEQ_ENABLE / BNE_ENABLE / JUMP_ENABLE / SHIFT_ENABLE  out  1 each  branch/jump/shift enables
//  SHIFTOP       out  2         00 srl, 01 sra, 10 ror, 11 sll
//  READ / WRITE  out  1 each    data memory request
//  MUX_MEMORY    out  1         write-back selects memory data
//  STALL         out  1         hold PC and instruction register
//  ILLEGAL_OP    out  1         sticky: unknown opcode seen
//  MEM_ERR       out  1         sticky: memory timeout seen
// BEHAVIOUR
//  Reset: all outputs 0, SHIFTOP=00, ALUOP=0, FSM=EXEC, timeout counter=0. Sticky flags clear only on reset.
//  Opcode map (hex): 00 loadi, 01 mov, 02 add, 03 sub, 04 and, 05 or, 06 j, 07 beq, 08 lwd, 09 lwi,
//   0A swd, 0B swi, 0C mul, 0D sll, 0E srl, 0F sra, 10 ror, 11 bne. ALUOP and mux values are unchanged
//   from the current decoder. Don't-care fields drive 0, never X.
//  Decode latency: 1 cycle. OPCODE is captured at the posedge when INSTR_VALID=1 and STALL=0.
//   The control word is valid from that edge.
//  INSTR_VALID=0 with STALL=0 latches a NOP control word (all enables 0).
//  Illegal opcode: latched as NOP and ILLEGAL_OP set at the same edge.
//  FSM states:
//   EXEC: non-memory op. REG_WRITE_EN = the decoded write flag.
//    A memory op (08-0B) drives READ or WRITE in the capture cycle and goes to MEM_WAIT.
//   MEM_WAIT: READ/WRITE held, STALL=1, REG_WRITE_EN=0, counter increments each cycle.
//    BUSYWAIT=0 at a posedge -> MEM_DONE.
//    Counter reaches TIMEOUT_CYC -> READ/WRITE drop, MEM_ERR set, next state MEM_DONE with write suppressed.
//   MEM_DONE (1 cycle): READ=WRITE=0, STALL=0, counter cleared.
//    REG_WRITE_EN=1 only for a load without timeout. Next state EXEC.
//  The STALL=1 cycle in MEM_WAIT also covers the request cycle, so the PC never advances
//   before MEM_DONE.
//  BUSYWAIT already low at the first MEM_WAIT edge: at least 1 wait cycle is still spent.
//   A new instruction is never captured in the same cycle as the request.
//  Reset asserted mid-transaction: READ/WRITE drop asynchronously and no write-back occurs.
//  BUSYWAIT high while in EXEC is ignored.
// STRUCTURE
//  Shared package: opcode localparams, ALUOP codes, SHIFTOP codes, FSM state encoding,
//   and the control-word struct/bus layout.
//  One sub-module: cu_opcode_decode (pure combinational OPCODE -> control word + illegal flag).
//  This module adds the pipeline register, the memory FSM and the timeout counter.
// TESTING
//  Reset: RESET_N=0 mid-MEM_WAIT -> all outputs 0 immediately; after release FSM=EXEC, no write.
//  add (02) with INSTR_VALID=1 -> next cycle ALUOP=001, MUX_2SCMPL=0, REG_WRITE_EN=1, STALL=0.
//  lwd (08), BUSYWAIT high 3 cycles -> READ=1, STALL=1 for 4 cycles; REG_WRITE_EN=1 one cycle in MEM_DONE;
//   MUX_MEMORY=1.
//  swi (0B), BUSYWAIT never drops, TIMEOUT_CYC=4 -> WRITE drops after 4 cycles, MEM_ERR=1 sticky,
//   no REG_WRITE_EN.
//  opcode 3F -> ILLEGAL_OP=1, all enables 0, next instruction (05 or) decodes normally.
//  INSTR_VALID toggled while STALL=1 -> OPCODE ignored until MEM_DONE; back-to-back lwi/swd both complete.

Source files
------------

// File: rtl/control_unit_fsm_pkg.sv
// Shared opcode map, ALU/shift codes, memory FSM states and the registered control word layout.
package control_unit_fsm_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;
  localparam logic [7:0] OP_MUL   = 8'h0C;
  localparam logic [7:0] OP_SLL   = 8'h0D;
  localparam logic [7:0] OP_SRL   = 8'h0E;
  localparam logic [7:0] OP_SRA   = 8'h0F;
  localparam logic [7:0] OP_ROR   = 8'h10;
  localparam logic [7:0] OP_BNE   = 8'h11;

  localparam logic [2:0] ALU_FWD   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_MUL   = 3'b100;
  localparam logic [2:0] ALU_SHIFT = 3'b101;

  localparam logic [1:0] SH_SRL = 2'b00;
  localparam logic [1:0] SH_SRA = 2'b01;
  localparam logic [1:0] SH_ROR = 2'b10;
  localparam logic [1:0] SH_SLL = 2'b11;

  typedef enum logic [1:0] {
    ST_EXEC     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] aluop;
    logic       mux_2scmpl;
    logic       mux_immd;
    logic       reg_write;
    logic       beq_en;
    logic       bne_en;
    logic       jump_en;
    logic       shift_en;
    logic [1:0] shiftop;
    logic       read;
    logic       write;
    logic       mux_memory;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_unit_fsm_decode.sv
// Pure combinational opcode -> control word decode; unknown opcodes give a NOP word plus illegal flag.
module cu_opcode_decode
  import control_unit_fsm_pkg::*;
#(
  parameter int unsigned OPCODE_W = 8
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_t               ctrl_o,
  output logic                illegal_o
);

  logic [31:0] op_ext;
  ctrl_t       c;
  logic        ill;

  always_comb begin
    op_ext = 32'(opcode_i);
    c      = CTRL_NOP;
    ill    = 1'b0;
    case (op_ext[7:0])
      OP_LOADI: begin c.mux_immd = 1'b1; c.reg_write = 1'b1; end
      OP_MOV:   c.reg_write = 1'b1;
      OP_ADD:   begin c.aluop = ALU_ADD; c.reg_write = 1'b1; end
      OP_SUB:   begin c.aluop = ALU_ADD; c.mux_2scmpl = 1'b1; c.reg_write = 1'b1; end
      OP_AND:   begin c.aluop = ALU_AND; c.reg_write = 1'b1; end
      OP_OR:    begin c.aluop = ALU_OR;  c.reg_write = 1'b1; end
      OP_J:     c.jump_en = 1'b1;
      OP_BEQ:   begin c.aluop = ALU_ADD; c.mux_2scmpl = 1'b1; c.beq_en = 1'b1; end
      OP_BNE:   begin c.aluop = ALU_ADD; c.mux_2scmpl = 1'b1; c.bne_en = 1'b1; end
      OP_LWD:   begin c.read = 1'b1; c.reg_write = 1'b1; c.mux_memory = 1'b1; end
      OP_LWI:   begin
        c.read = 1'b1; c.reg_write = 1'b1; c.mux_memory = 1'b1; c.mux_immd = 1'b1;
      end
      OP_SWD:   c.write = 1'b1;
      OP_SWI:   begin c.write = 1'b1; c.mux_immd = 1'b1; end
      OP_MUL:   begin c.aluop = ALU_MUL; c.reg_write = 1'b1; end
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: begin
        c.aluop     = ALU_SHIFT;
        c.mux_immd  = 1'b1;
        c.shift_en  = 1'b1;
        c.reg_write = 1'b1;
        case (op_ext[7:0])
          OP_SLL:  c.shiftop = SH_SLL;
          OP_SRA:  c.shiftop = SH_SRA;
          OP_ROR:  c.shiftop = SH_ROR;
          default: c.shiftop = SH_SRL;
        endcase
      end
      default:  ill = 1'b1;
    endcase
    // Opcodes wider than the 8-bit map are legal only when the extra bits are zero.
    if (|op_ext[31:8]) begin
      c   = CTRL_NOP;
      ill = 1'b1;
    end
  end

  assign ctrl_o    = c;
  assign illegal_o = ill;

endmodule

// File: rtl/control_unit_fsm.sv
// Registered control unit: 1-cycle decode, data-memory handshake FSM with BUSYWAIT timeout.
// STALL holds the PC from the request cycle until MEM_DONE; OPCODE is ignored while stalled.
module control_unit_fsm
  import control_unit_fsm_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 8,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TMO_W       = 8
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                INSTR_VALID,
  input  logic                BUSYWAIT,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic                MUX_2SCMPL,
  output logic                MUX_IMMD,
  output logic                REG_WRITE_EN,
  output logic                BEQ_ENABLE,
  output logic                BNE_ENABLE,
  output logic                JUMP_ENABLE,
  output logic                SHIFT_ENABLE,
  output logic [1:0]          SHIFTOP,
  output logic                READ,
  output logic                WRITE,
  output logic                MUX_MEMORY,
  output logic                STALL,
  output logic                ILLEGAL_OP,
  output logic                MEM_ERR
);

  state_e           state_q, state_d;
  ctrl_t            cw_q, cw_d, dec_cw;
  logic             dec_ill;
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             tmo_q, tmo_d;
  logic             ill_q, ill_d;
  logic             err_q, err_d;
  logic             capture;

  cu_opcode_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode_i  (OPCODE),
    .ctrl_o    (dec_cw),
    .illegal_o (dec_ill)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_EXEC;
      cw_q    <= CTRL_NOP;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    ill_d   = ill_q;
    err_d   = err_q;
    capture = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    case (state_q)
      ST_MEM_WAIT: begin
        // Completion wins over a timeout that would fire on the same edge.
        if (!BUSYWAIT) begin
          state_d = ST_MEM_DONE;
          cnt_d   = '0;
        end else if ((TIMEOUT_CYC != 0) && (cnt_inc == TMO_W'(TIMEOUT_CYC))) begin
          state_d = ST_MEM_DONE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: capture = 1'b1;
    endcase
    if (capture) begin
      tmo_d = 1'b0;
      if (INSTR_VALID) begin
        cw_d = dec_cw;
        if (dec_ill) ill_d = 1'b1;
      end else begin
        cw_d = CTRL_NOP;
      end
      state_d = (cw_d.read || cw_d.write) ? ST_MEM_WAIT : ST_EXEC;
    end
  end

  assign STALL        = (state_q == ST_MEM_WAIT);
  assign READ         = cw_q.read  & STALL;
  assign WRITE        = cw_q.write & STALL;
  assign REG_WRITE_EN = cw_q.reg_write &
                        ((state_q == ST_EXEC) || ((state_q == ST_MEM_DONE) && !tmo_q));
  assign ALUOP        = ALUOP_W'(cw_q.aluop);
  assign MUX_2SCMPL   = cw_q.mux_2scmpl;
  assign MUX_IMMD     = cw_q.mux_immd;
  assign BEQ_ENABLE   = cw_q.beq_en;
  assign BNE_ENABLE   = cw_q.bne_en;
  assign JUMP_ENABLE  = cw_q.jump_en;
  assign SHIFT_ENABLE = cw_q.shift_en;
  assign SHIFTOP      = cw_q.shiftop;
  assign MUX_MEMORY   = cw_q.mux_memory;
  assign ILLEGAL_OP   = ill_q;
  assign MEM_ERR      = err_q;

endmodule
